// File: rtl/mult_error_accumulator.sv
// mult_error_accumulator
//
// Error-metric sink for the approximate-multiplier study. Accepts a stream of
// (exact, approximate) signed product pairs over a valid/ready handshake for a
// programmed number of samples and accumulates the exact sum, the approximate
// sum and the per-sample absolute error sum. The absolute difference of the
// two final sums and, optionally, the largest per-sample absolute error are
// also reported.
//
// Optional feature macro: MULT_ERR_MAX_TRACK_EN
//   defined   -> o_max_err tracks the running maximum |approx - exact|
//   undefined -> no max register/comparator; o_max_err is tied to 0
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           start a run (honoured only when idle)
//   i_n_samples       number of pairs in the run, latched on start
//   i_valid/o_ready   pair handshake; a pair is taken when both are high
//   i_exact/i_approx  signed product pair
//   o_busy            high whenever the block is not idle
//   o_done            one-cycle pulse, results final in this cycle
//   o_count           pairs accepted in the current or last run
//   o_exact_sum       signed sum of i_exact
//   o_approx_sum      signed sum of i_approx
//   o_abs_err_sum     unsigned sum of |i_approx - i_exact|
//   o_sum_diff_abs    unsigned |o_approx_sum - o_exact_sum|
//   o_max_err         unsigned maximum |i_approx - i_exact| (or 0)

module mult_error_accumulator #(
    parameter int PROD_W = 16,
    parameter int CNT_W  = 17,
    parameter int ACC_W  = 40
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [CNT_W-1:0]         i_n_samples,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [PROD_W-1:0] i_exact,
    input  logic signed [PROD_W-1:0] i_approx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_count,
    output logic signed [ACC_W-1:0]  o_exact_sum,
    output logic signed [ACC_W-1:0]  o_approx_sum,
    output logic [ACC_W-1:0]         o_abs_err_sum,
    output logic [ACC_W-1:0]         o_sum_diff_abs,
    output logic [PROD_W:0]          o_max_err
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        n_lat;
    logic                    accept;
    logic signed [PROD_W:0]  diff_in;
    logic signed [PROD_W:0]  diff_p0;
    logic                    vld_p0;
    logic [PROD_W:0]         abs_p0;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // Negating the PROD_W+1 bit difference cannot overflow: the difference of
    // two PROD_W bit values never reaches the most-negative PROD_W+1 code.
    function automatic logic [PROD_W:0] abs_diff(input logic signed [PROD_W:0] d);
        logic [PROD_W:0] u;
        u = d;
        return d[PROD_W] ? -u : u;
    endfunction

    function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-1:0] u;
        u = v;
        return v[ACC_W-1] ? -u : u;
    endfunction

    assign accept  = i_valid && o_ready;
    assign diff_in = {i_approx[PROD_W-1], i_approx} - {i_exact[PROD_W-1], i_exact};
    assign abs_p0  = abs_diff(diff_p0);

`ifdef MULT_ERR_MAX_TRACK_EN
    logic [PROD_W:0] max_err;
    assign o_max_err = max_err;
`else
    assign o_max_err = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_ready        <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            vld_p0         <= 1'b0;
            diff_p0        <= '0;
            n_lat          <= '0;
            o_count        <= '0;
            o_exact_sum    <= '0;
            o_approx_sum   <= '0;
            o_abs_err_sum  <= '0;
            o_sum_diff_abs <= '0;
`ifdef MULT_ERR_MAX_TRACK_EN
            max_err        <= '0;
`endif
        end else begin
            o_done <= 1'b0;

            // Stage p0: register the difference of each accepted pair
            vld_p0 <= accept;
            if (accept) begin
                diff_p0      <= diff_in;
                o_count      <= o_count + 1'b1;
                o_exact_sum  <= o_exact_sum + sext(i_exact);
                o_approx_sum <= o_approx_sum + sext(i_approx);
            end

            // Stage p1: accumulate |diff| one cycle behind the sums
            if (vld_p0) begin
                o_abs_err_sum <= o_abs_err_sum + {{(ACC_W-PROD_W-1){1'b0}}, abs_p0};
`ifdef MULT_ERR_MAX_TRACK_EN
                if (abs_p0 > max_err)
                    max_err <= abs_p0;
`endif
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        n_lat          <= i_n_samples;
                        o_count        <= '0;
                        o_exact_sum    <= '0;
                        o_approx_sum   <= '0;
                        o_abs_err_sum  <= '0;
                        o_sum_diff_abs <= '0;
`ifdef MULT_ERR_MAX_TRACK_EN
                        max_err        <= '0;
`endif
                        o_busy         <= 1'b1;
                        if (i_n_samples != '0) begin
                            state   <= RUN;
                            o_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (accept && (o_count + 1'b1 == n_lat)) begin
                        state   <= DRAIN1;
                        o_ready <= 1'b0;
                    end
                end
                DRAIN1: state <= DRAIN2;
                DRAIN2: begin
                    // Sums have been final since the last accept
                    o_sum_diff_abs <= abs_acc(o_approx_sum - o_exact_sum);
                    state          <= DONE;
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_error_accumulator.sv
// Self-checking bench for mult_error_accumulator (default parameters).
module tb_mult_error_accumulator;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [16:0]        n_samples = '0;
    logic               valid = 1'b0;
    logic               ready;
    logic signed [15:0] exact = '0;
    logic signed [15:0] approx = '0;
    logic               busy;
    logic               done;
    logic [16:0]        count;
    logic signed [39:0] exact_sum;
    logic signed [39:0] approx_sum;
    logic [39:0]        abs_err_sum;
    logic [39:0]        sum_diff_abs;
    logic [16:0]        max_err;

    int     cyc = 0;
    int     n_cmp = 0;
    int     n_fail = 0;
    longint ex_q[$];
    longint ap_q[$];
    string  nm[6] = '{"exact_sum", "approx_sum", "abs_err_sum", "sum_diff_abs", "max_err", "count"};

    mult_error_accumulator #(.PROD_W(16), .CNT_W(17), .ACC_W(40)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_n_samples(n_samples),
        .i_valid(valid), .o_ready(ready), .i_exact(exact), .i_approx(approx),
        .o_busy(busy), .o_done(done), .o_count(count),
        .o_exact_sum(exact_sum), .o_approx_sum(approx_sum),
        .o_abs_err_sum(abs_err_sum), .o_sum_diff_abs(sum_diff_abs),
        .o_max_err(max_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: totals of the queued pairs computed with plain arithmetic
    function automatic void model(output longint e[6]);
        longint es = 0, as = 0, ae = 0, mx = 0, d;
        foreach (ex_q[i]) begin
            es += ex_q[i];
            as += ap_q[i];
            d = ap_q[i] - ex_q[i];
            if (d < 0) d = -d;
            ae += d;
            if (d > mx) mx = d;
        end
        e[0] = es;
        e[1] = as;
        e[2] = ae;
        e[3] = (as > es) ? as - es : es - as;
`ifdef MULT_ERR_MAX_TRACK_EN
        e[4] = mx;
`else
        e[4] = 0;
`endif
        e[5] = ex_q.size();
    endfunction

    function automatic void snap(output longint g[6]);
        g[0] = longint'(exact_sum);
        g[1] = longint'(approx_sum);
        g[2] = longint'(abs_err_sum);
        g[3] = longint'(sum_diff_abs);
        g[4] = longint'(max_err);
        g[5] = longint'(count);
    endfunction

    function automatic void push_pair(input longint e, input longint a);
        ex_q.push_back(e);
        ap_q.push_back(a);
    endfunction

    function automatic void push_random(input int n);
        logic signed [15:0] r1, r2;
        for (int i = 0; i < n; i++) begin
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            push_pair(longint'(r1), longint'(r2));
        end
    endfunction

    // Drives one run of the queued pairs; entered and left just after a rising edge.
    // ref_cyc is the cycle of the last accept (or of the start edge when n==0).
    task automatic drive_run(input int n, input int gap_pct, input int glitch_at,
                             input bit hold_after, output int ref_cyc,
                             output int done_cyc, output int pulses, output bit tmo);
        int idx = 0;
        int guard = 0;
        bit take;
        start = 1'b1;
        n_samples = 17'(n);
        @(posedge clk); #1;
        start = 1'b0;
        ref_cyc = cyc;
        while (idx < n && guard < 300000) begin
            valid  = ($urandom_range(99) >= gap_pct);
            exact  = 16'(ex_q[idx]);
            approx = 16'(ap_q[idx]);
            start  = (idx == glitch_at);
            n_samples = 17'd1;
            take = valid && ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (take) begin
                idx++;
                ref_cyc = cyc;
            end
            guard++;
        end
        if (hold_after) begin
            valid = 1'b1; exact = 16'sd777; approx = -16'sd5;
        end else begin
            valid = 1'b0;
        end
        pulses = 0;
        done_cyc = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        valid = 1'b0;
        tmo = (idx < n) || (pulses == 0);
    endtask

    task automatic test_reset();
        longint g[6], e[6];
        rst = 1'b1; valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ex_q.delete(); ap_q.delete();
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL reset %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if ({ready, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset ready/busy/done got %b expected 000", {ready, busy, done});
        end
        valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 valid = 1'b0;
        n_cmp++;
        if (count !== 17'd0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_valid count=%0d ready=%b expected 0 0", count, ready);
        end
    endtask

    task automatic test_single();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        ex_q.delete(); ap_q.delete();
        push_pair(100, 96);
        drive_run(1, 0, -1, 0, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL single %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 3 || p != 1) begin
            n_fail++;
            $display("FAIL single_done latency=%0d pulses=%0d expected 3 1", dc - rc, p);
        end
    endtask

    task automatic load_four();
        ex_q.delete(); ap_q.delete();
        push_pair(10, 12); push_pair(-20, -16); push_pair(5, 5); push_pair(-8, -10);
    endtask

    task automatic test_back_to_back();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        load_four();
        drive_run(4, 0, -1, 1, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL b2b %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 3 || p != 1) begin
            n_fail++;
            $display("FAIL b2b_done latency=%0d pulses=%0d expected 3 1", dc - rc, p);
        end
        n_cmp++;
        if (exact_sum !== -40'sd13 || abs_err_sum !== 40'd8) begin
            n_fail++;
            $display("FAIL b2b_literal exact_sum=%0d abs_err_sum=%0d expected -13 8", exact_sum, abs_err_sum);
        end
    endtask

    task automatic test_throttled();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        load_four();
        drive_run(4, 50, -1, 0, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL throttled %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 3 || p != 1) begin
            n_fail++;
            $display("FAIL throttled_done latency=%0d pulses=%0d expected 3 1", dc - rc, p);
        end
    endtask

    task automatic test_extremes();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        ex_q.delete(); ap_q.delete();
        push_pair(16384, -16384);
        push_pair(-32768, 32767);
        push_pair(32767, -32768);
        drive_run(3, 0, -1, 0, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL extremes %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 3 || p != 1) begin
            n_fail++;
            $display("FAIL extremes_done latency=%0d pulses=%0d expected 3 1", dc - rc, p);
        end
    endtask

    task automatic test_n_zero();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        ex_q.delete(); ap_q.delete();
        drive_run(0, 0, -1, 0, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL n_zero %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 1 || p != 1) begin
            n_fail++;
            $display("FAIL n_zero_done latency=%0d pulses=%0d expected 1 1", dc - rc, p);
        end
    endtask

    task automatic test_ignored_start();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        ex_q.delete(); ap_q.delete();
        push_random(10);
        drive_run(10, 30, 2, 0, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL ignored_start %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 3 || p != 1) begin
            n_fail++;
            $display("FAIL ignored_start_done latency=%0d pulses=%0d expected 3 1", dc - rc, p);
        end
    endtask

    task automatic test_random();
        longint g[6], e[6];
        int rc, dc, p, n;
        bit tmo;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(24, 1);
            ex_q.delete(); ap_q.delete();
            push_random(n);
            drive_run(n, $urandom_range(60), -1, 0, rc, dc, p, tmo);
            snap(g); model(e);
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (g[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL random%0d %s got %0d expected %0d", r, nm[i], g[i], e[i]);
                end
            end
            n_cmp++;
            if (tmo || dc - rc != 3 || p != 1) begin
                n_fail++;
                $display("FAIL random%0d_done latency=%0d pulses=%0d expected 3 1", r, dc - rc, p);
            end
        end
    endtask

    task automatic test_reset_mid();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        ex_q.delete(); ap_q.delete();
        push_random(8);
        start = 1'b1; n_samples = 17'd8;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; exact = 16'(ex_q[i]); approx = 16'(ap_q[i]);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ex_q.delete(); ap_q.delete();
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL reset_mid %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if ({ready, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid ready/busy/done got %b expected 000", {ready, busy, done});
        end
        push_random(2);
        drive_run(2, 0, -1, 0, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL after_reset %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 3 || p != 1) begin
            n_fail++;
            $display("FAIL after_reset_done latency=%0d pulses=%0d expected 3 1", dc - rc, p);
        end
    endtask

    // All 8x8 signed operand pairs: exact product vs. a product with its two
    // low bits truncated (a simple approximate multiplier).
    task automatic test_sweep();
        longint g[6], e[6];
        int rc, dc, p;
        bit tmo;
        longint prod;
        ex_q.delete(); ap_q.delete();
        for (int a = -128; a < 128; a++) begin
            for (int b = -128; b < 128; b++) begin
                prod = longint'(a) * longint'(b);
                push_pair(prod, prod & ~64'sd3);
            end
        end
        drive_run(65536, 0, -1, 0, rc, dc, p, tmo);
        snap(g); model(e);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_fail++;
                $display("FAIL sweep %s got %0d expected %0d", nm[i], g[i], e[i]);
            end
        end
        n_cmp++;
        if (tmo || dc - rc != 3 || p != 1) begin
            n_fail++;
            $display("FAIL sweep_done latency=%0d pulses=%0d expected 3 1", dc - rc, p);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_throttled();
        test_extremes();
        test_n_zero();
        test_ignored_start();
        test_random();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
